maxpool_with_mem: RTL and testbench



---
 rtl/maxpool_with_mem_if.sv | 22 ++
 rtl/maxpool_with_mem.sv | 227 ++++++++++++++++++++++
 tb/tb_maxpool_with_mem.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_with_mem_if.sv
// Control/handshake bundle between the max-pool engine (master) and its job/memory controller (slave).
interface maxpool_with_mem_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  start;
  logic                  done;
  logic [ADDR_WIDTH-1:0] input_addr;
  logic [ADDR_WIDTH-1:0] output_addr;
  logic                  mem_w;
  logic                  mem_sel;
  logic                  ready;

  modport master (
    input  start, input_addr, output_addr, ready,
    output done, mem_w, mem_sel
  );

  modport slave (
    output start, input_addr, output_addr, ready,
    input  done, mem_w, mem_sel
  );
endinterface

// File: rtl/maxpool_with_mem.sv
// Loads a HEIGHTxWIDTH signed matrix over a shared tri-state bus, max-pools POOLxPOOL windows, writes results back.
// Optional MAXPOOL_INDEX_EN: also reports the raster position of each window's winner above the value field.
module maxpool_with_mem #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATABUS_WIDTH = 32,
  parameter int HEIGHT        = 4,
  parameter int WIDTH         = 4,
  parameter int POOL          = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  maxpool_with_mem_if.master       ctl,
  inout  wire [ADDR_WIDTH-1:0]     address_bus,
  inout  wire [DATABUS_WIDTH-1:0]  data_bus
);
  localparam int NELEM  = HEIGHT * WIDTH;
  localparam int BUF_AW = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam int CW     = 16;
  localparam int IDXW   = (POOL * POOL > 1) ? $clog2(POOL * POOL) : 1;
  localparam logic [CW-1:0] LAST_LD = CW'(NELEM - 1);
  localparam logic [CW-1:0] LAST_K  = CW'(POOL - 1);
  localparam logic [CW-1:0] LAST_WR = CW'(HEIGHT / POOL - 1);
  localparam logic [CW-1:0] LAST_WC = CW'(WIDTH / POOL - 1);
  localparam logic [CW-1:0] POOL_C  = CW'(POOL);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REDUCE, S_WRITE, S_NEXT, S_FINISHED} state_t;

  state_t                        state_reg, state_next;
  logic                          done_reg, done_next;
  logic                          mem_w_reg, mem_w_next;
  logic                          mem_sel_reg, mem_sel_next;
  logic                          stall_reg, stall_next;
  logic [ADDR_WIDTH-1:0]         addr_reg, addr_next;
  logic [CW-1:0]                 ld_cnt_reg, ld_cnt_next;
  logic [CW-1:0]                 kr_reg, kr_next, kc_reg, kc_next;
  logic [CW-1:0]                 wr_reg, wr_next, wc_reg, wc_next;
  logic signed [DATA_WIDTH-1:0]  acc_reg, acc_next;
  logic                          buf_we;
  logic                          accept;
  logic [CW-1:0]                 rd_idx;
  logic signed [DATA_WIDTH-1:0]  elem;
  logic [DATABUS_WIDTH-1:0]      data_out;
  logic signed [DATA_WIDTH-1:0]  buf_mem [NELEM];
`ifdef MAXPOOL_INDEX_EN
  logic [IDXW-1:0]               idx_reg, idx_next, k_idx;
`endif

  // Element of the current window at offset (kr, kc), row-major in the buffer.
  assign rd_idx = (wr_reg * POOL_C + kr_reg) * WIDTH_C + wc_reg * POOL_C + kc_reg;
  assign elem   = buf_mem[rd_idx[BUF_AW-1:0]];
  assign accept = mem_sel_reg && !stall_reg && ctl.ready;

  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[ld_cnt_reg[BUF_AW-1:0]] <= data_bus[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      done_reg    <= 1'b0;
      mem_w_reg   <= 1'b0;
      mem_sel_reg <= 1'b0;
      stall_reg   <= 1'b0;
      addr_reg    <= '0;
      ld_cnt_reg  <= '0;
      kr_reg      <= '0;
      kc_reg      <= '0;
      wr_reg      <= '0;
      wc_reg      <= '0;
      acc_reg     <= '0;
`ifdef MAXPOOL_INDEX_EN
      idx_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      done_reg    <= done_next;
      mem_w_reg   <= mem_w_next;
      mem_sel_reg <= mem_sel_next;
      stall_reg   <= stall_next;
      addr_reg    <= addr_next;
      ld_cnt_reg  <= ld_cnt_next;
      kr_reg      <= kr_next;
      kc_reg      <= kc_next;
      wr_reg      <= wr_next;
      wc_reg      <= wc_next;
      acc_reg     <= acc_next;
`ifdef MAXPOOL_INDEX_EN
      idx_reg     <= idx_next;
`endif
    end
  end

`ifdef MAXPOOL_INDEX_EN
  assign k_idx = IDXW'(kr_reg * POOL_C + kc_reg);
`endif

  always_comb begin
    state_next   = state_reg;
    done_next    = done_reg;
    mem_w_next   = mem_w_reg;
    mem_sel_next = mem_sel_reg;
    stall_next   = stall_reg;
    addr_next    = addr_reg;
    ld_cnt_next  = ld_cnt_reg;
    kr_next      = kr_reg;
    kc_next      = kc_reg;
    wr_next      = wr_reg;
    wc_next      = wc_reg;
    acc_next     = acc_reg;
    buf_we       = 1'b0;
`ifdef MAXPOOL_INDEX_EN
    idx_next     = idx_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        done_next = 1'b0;
        if (ctl.start) begin
          addr_next    = ctl.input_addr;
          mem_sel_next = 1'b1;
          mem_w_next   = 1'b0;
          ld_cnt_next  = '0;
          state_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (stall_reg) begin
          stall_next   = 1'b0;
          mem_sel_next = 1'b1;
        end else if (accept) begin
          buf_we       = 1'b1;
          mem_sel_next = 1'b0;
          if (ld_cnt_reg == LAST_LD) begin
            addr_next  = ctl.output_addr;
            kr_next    = '0;
            kc_next    = '0;
            wr_next    = '0;
            wc_next    = '0;
            state_next = S_REDUCE;
          end else begin
            addr_next   = addr_reg + ADDR_WIDTH'(1);
            ld_cnt_next = ld_cnt_reg + CW'(1);
            stall_next  = 1'b1;
          end
        end
      end
      S_REDUCE: begin
        // First element seeds the accumulator; later ones win only when strictly greater.
        if ((kr_reg == '0 && kc_reg == '0) || (elem > acc_reg)) begin
          acc_next = elem;
`ifdef MAXPOOL_INDEX_EN
          idx_next = k_idx;
`endif
        end
        if (kc_reg == LAST_K) begin
          kc_next = '0;
          if (kr_reg == LAST_K) begin
            kr_next      = '0;
            mem_sel_next = 1'b1;
            mem_w_next   = 1'b1;
            state_next   = S_WRITE;
          end else begin
            kr_next = kr_reg + CW'(1);
          end
        end else begin
          kc_next = kc_reg + CW'(1);
        end
      end
      S_WRITE: begin
        if (stall_reg) begin
          stall_next = 1'b0;
          state_next = S_NEXT;
        end else if (accept) begin
          mem_sel_next = 1'b0;
          mem_w_next   = 1'b0;
          stall_next   = 1'b1;
        end
      end
      S_NEXT: begin
        addr_next = addr_reg + ADDR_WIDTH'(1);
        if (wc_reg == LAST_WC) begin
          wc_next = '0;
          if (wr_reg == LAST_WR) begin
            wr_next    = '0;
            done_next  = 1'b1;
            state_next = S_FINISHED;
          end else begin
            wr_next    = wr_reg + CW'(1);
            state_next = S_REDUCE;
          end
        end else begin
          wc_next    = wc_reg + CW'(1);
          state_next = S_REDUCE;
        end
      end
      S_FINISHED: begin
        if (!ctl.start) begin
          done_next  = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef MAXPOOL_INDEX_EN
  always_comb begin
    data_out                     = '0;
    data_out[DATA_WIDTH-1:0]     = acc_reg;
    data_out[DATA_WIDTH +: IDXW] = idx_reg;
  end
`else
  assign data_out = {{(DATABUS_WIDTH - DATA_WIDTH){acc_reg[DATA_WIDTH-1]}}, acc_reg};
`endif

  assign address_bus = (state_reg == S_LOAD || state_reg == S_REDUCE ||
                        state_reg == S_WRITE || state_reg == S_NEXT) ? addr_reg : 'z;
  assign data_bus    = (state_reg == S_WRITE && mem_w_reg) ? data_out : 'z;

  assign ctl.done    = done_reg;
  assign ctl.mem_w   = mem_w_reg;
  assign ctl.mem_sel = mem_sel_reg;

  logic unused_bits;
  assign unused_bits = &{1'b0, data_bus[DATABUS_WIDTH-1:DATA_WIDTH], rd_idx[CW-1:BUF_AW], address_bus};
endmodule

// File: tb/tb_maxpool_with_mem.sv
// Directed bench for maxpool_with_mem: memory model on the shared bus, write log, ready-stall and reset-abort cases.
module tb_maxpool_with_mem;
  localparam logic [7:0]  PROBE_A = 8'h5A;
  localparam logic [31:0] PROBE_D = 32'hA5C3_3C5A;

  logic clk;
  logic rst_n;
  wire [7:0]  address_bus;
  wire [31:0] data_bus;

  maxpool_with_mem_if #(.ADDR_WIDTH(8)) mif ();

  maxpool_with_mem #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .DATABUS_WIDTH(32),
    .HEIGHT(4), .WIDTH(4), .POOL(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ctl(mif),
    .address_bus(address_bus),
    .data_bus(data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Memory model and bus drivers
  logic [31:0] mem [256];
  logic        probe_en;
  logic        tb_den;
  logic [31:0] tb_dval;
  logic        stall_test;
  logic        ready_low;
  logic        clear_req;
  logic [7:0]  in_base;

  int          ld_cnt, wr_cnt, ld_err, ld_low, wr_low;
  logic [7:0]  wr_a [16];
  logic [31:0] wr_d [16];
  logic [7:0]  exp_a [4];
  logic [31:0] exp_d [4];

  always_comb begin
    tb_den  = 1'b0;
    tb_dval = '0;
    if (probe_en) begin
      tb_den  = 1'b1;
      tb_dval = PROBE_D;
    end else if (mif.mem_sel && !mif.mem_w) begin
      tb_den  = 1'b1;
      tb_dval = mem[address_bus];
    end
  end
  assign data_bus    = tb_den ? tb_dval : 32'bz;
  assign address_bus = probe_en ? PROBE_A : 8'bz;

  // Refuse the 5th load and the 2nd write for three requested cycles each.
  always_comb begin
    ready_low = 1'b0;
    if (stall_test && mif.mem_sel) begin
      if (!mif.mem_w && ld_cnt == 4 && ld_low < 3) ready_low = 1'b1;
      if (mif.mem_w && wr_cnt == 1 && wr_low < 3) ready_low = 1'b1;
    end
    mif.ready = !ready_low;
  end

  always @(posedge clk) begin
    if (clear_req) begin
      ld_cnt <= 0; wr_cnt <= 0; ld_err <= 0; ld_low <= 0; wr_low <= 0;
    end else if (rst_n && mif.mem_sel) begin
      if (ready_low) begin
        if (mif.mem_w) wr_low <= wr_low + 1;
        else           ld_low <= ld_low + 1;
      end else if (mif.ready) begin
        if (mif.mem_w) begin
          if (wr_cnt < 16) begin
            wr_a[wr_cnt] <= address_bus;
            wr_d[wr_cnt] <= data_bus;
          end
          $display("write addr=%02h data=%08h", address_bus, data_bus);
          wr_cnt <= wr_cnt + 1;
        end else begin
          if (address_bus !== 8'(in_base + 8'(ld_cnt))) ld_err <= ld_err + 1;
          ld_cnt <= ld_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (stall_test && ld_cnt == 4 && ld_low >= 1) begin
      check("hold_ld_sel", 32'(mif.mem_sel), 32'd1);
      check("hold_ld_w", 32'(mif.mem_w), 32'd0);
    end
    if (stall_test && wr_cnt == 1 && wr_low >= 1) begin
      check("hold_wr_sel", 32'(mif.mem_sel), 32'd1);
      check("hold_wr_w", 32'(mif.mem_w), 32'd1);
    end
  end

  function automatic logic [31:0] exp_word(input logic [7:0] v, input logic [1:0] idx);
`ifdef MAXPOOL_INDEX_EN
    return {22'd0, idx, v};
`else
    return {{24{v[7]}}, v} | {30'd0, idx & 2'b00};
`endif
  endfunction

  task automatic bus_z(input string tag);
    probe_en = 1'b1;
    #1;
    check({tag, "_addr_z"}, 32'(address_bus), 32'(PROBE_A));
    check({tag, "_data_z"}, data_bus, PROBE_D);
    probe_en = 1'b0;
  endtask

  task automatic start_job(input logic [7:0] ia, input logic [7:0] oa, input logic stl);
    mif.input_addr  = ia;
    mif.output_addr = oa;
    in_base         = ia;
    stall_test      = stl;
    clear_req       = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    mif.start = 1'b1;
  endtask

  task automatic finish_job(input string tag);
    for (int n = 0; n < 400 && !mif.done; n++) @(negedge clk);
    check({tag, "_done"}, 32'(mif.done), 32'd1);
    check({tag, "_nwr"}, 32'(wr_cnt), 32'd4);
    check({tag, "_nld"}, 32'(ld_cnt), 32'd16);
    check({tag, "_ldseq"}, 32'(ld_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_wa"}, 32'(wr_a[i]), 32'(exp_a[i]));
      check({tag, "_wd"}, wr_d[i], exp_d[i]);
    end
    // start still high: job must not rerun
    repeat (6) @(negedge clk);
    check({tag, "_hold_done"}, 32'(mif.done), 32'd1);
    check({tag, "_hold_sel"}, 32'(mif.mem_sel), 32'd0);
    check({tag, "_hold_nld"}, 32'(ld_cnt), 32'd16);
    bus_z({tag, "_fin"});
    mif.start = 1'b0;
    @(negedge clk);
    check({tag, "_idle_done"}, 32'(mif.done), 32'd0);
  endtask

  task automatic set_exp(input logic [7:0] base, input logic [7:0] v0, input logic [7:0] v1,
                         input logic [7:0] v2, input logic [7:0] v3, input logic [7:0] ix);
    exp_a[0] = base;            exp_d[0] = exp_word(v0, ix[1:0]);
    exp_a[1] = 8'(base + 8'd1); exp_d[1] = exp_word(v1, ix[3:2]);
    exp_a[2] = 8'(base + 8'd2); exp_d[2] = exp_word(v2, ix[5:4]);
    exp_a[3] = 8'(base + 8'd3); exp_d[3] = exp_word(v3, ix[7:6]);
  endtask

  logic [7:0] mat3 [16];

  initial begin
    rst_n = 1'b0; mif.start = 1'b0; mif.input_addr = '0; mif.output_addr = '0;
    probe_en = 1'b0; stall_test = 1'b0; clear_req = 1'b0; in_base = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) mem[8'h10 + i] = 32'(i + 1);
    for (int i = 0; i < 16; i++) mem[8'h80 + i] = 32'hABCD_12FB;
    mat3 = '{8'd3, 8'd7, 8'hFF, 8'hF8,  8'd7, 8'd2, 8'h80, 8'hFE,
             8'd0, 8'hFD, 8'd127, 8'h80, 8'd5, 8'd5, 8'd127, 8'd1};
    for (int i = 0; i < 16; i++) mem[8'h20 + i] = {24'h5A5A5A, mat3[i]};

    repeat (3) @(negedge clk);
    check("rst_done", 32'(mif.done), 32'd0);
    check("rst_sel", 32'(mif.mem_sel), 32'd0);
    check("rst_w", 32'(mif.mem_w), 32'd0);
    bus_z("rst");
    rst_n = 1'b1;
    @(negedge clk);

    $display("job ramp in=10 out=40");
    set_exp(8'h40, 8'd6, 8'd8, 8'd14, 8'd16, 8'b11_11_11_11);
    start_job(8'h10, 8'h40, 1'b0);
    finish_job("ramp");

    $display("job neg5 in=80 out=90");
    set_exp(8'h90, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'b00_00_00_00);
    start_job(8'h80, 8'h90, 1'b0);
    finish_job("neg5");

    $display("job mixed in=20 out=FE stalls");
    set_exp(8'hFE, 8'd7, 8'hFF, 8'd5, 8'd127, 8'b00_10_00_01);
    start_job(8'h20, 8'hFE, 1'b1);
    finish_job("mixed");
    check("mixed_ld_low", 32'(ld_low), 32'd3);
    check("mixed_wr_low", 32'(wr_low), 32'd3);

    $display("job abort in=10 out=60");
    start_job(8'h10, 8'h60, 1'b0);
    for (int n = 0; n < 200 && !(ld_cnt == 8 && mif.mem_sel); n++) @(negedge clk);
    check("abort_reach", 32'(ld_cnt), 32'd8);
    rst_n = 1'b0;
    mif.start = 1'b0;
    @(negedge clk);
    check("abort_sel", 32'(mif.mem_sel), 32'd0);
    check("abort_w", 32'(mif.mem_w), 32'd0);
    check("abort_done", 32'(mif.done), 32'd0);
    bus_z("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_nwr", 32'(wr_cnt), 32'd0);
    check("abort_nld", 32'(ld_cnt), 32'd8);

    $display("job rerun in=10 out=40");
    set_exp(8'h40, 8'd6, 8'd8, 8'd14, 8'd16, 8'b11_11_11_11);
    start_job(8'h10, 8'h40, 1'b0);
    finish_job("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
